// File: rtl/calc_cmd_sequencer_if.sv
// Command handshake between the keypad/host front end and the calculator command sequencer.
// A command transfers on a rising edge where cmd_valid and cmd_ready are both high.
interface calc_cmd_sequencer_if #(
    parameter int DATA_W = 4,
    parameter int OP_W   = 3
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [DATA_W-1:0] cmd_operand;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_operand,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_operand,
        output cmd_ready
    );
endinterface

// File: rtl/calc_cmd_sequencer.sv
// Queues calculator commands in a small FIFO and replays each one as a fixed sequence
// of datapath control strobes.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting; pops the FIFO head when one is present
// LDNUM | drive operand onto values, load input register
// LDOP  | drive opcode, load opcode register (ALU ops only)
// EXEC  | load accumulator from input register (LOAD) or ALU result
// SHOW  | switch display to accumulator, signal done
// CLR   | clear input, opcode and result registers, clear error, signal done
module calc_cmd_sequencer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 4,
    parameter int OP_W   = 3
) (
    input  logic                clk,
    input  logic                reset,
    calc_cmd_sequencer_if.slave cmd,
    output logic [DATA_W-1:0]   values,
    output logic                ld_number,
    output logic                clr_number,
    output logic                ld_opcode,
    output logic                clr_opcode,
    output logic [OP_W-1:0]     opcode_out,
    output logic                sel_mux_alu,
    output logic                ld_result,
    output logic                clr_result,
    output logic                sel_mux_display,
    output logic                busy,
    output logic                done,
    output logic                err_illegal,
    output logic [2:0]          state_dbg
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = OP_W + DATA_W;
    localparam logic [OP_W-1:0] OP_CLEAR = '0;
    localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LDNUM = 3'd1,
        S_LDOP  = 3'd2,
        S_EXEC  = 3'd3,
        S_SHOW  = 3'd4,
        S_CLR   = 3'd5
    } state_e;

    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    state_e            state_q, state_d;
    logic [OP_W-1:0]   cur_op_q, cur_op_d;
    logic [DATA_W-1:0] cur_operand_q, cur_operand_d;
    logic [DATA_W-1:0] values_q, values_d;
    logic [OP_W-1:0]   opcode_out_q, opcode_out_d;
    logic              ld_number_q, ld_number_d;
    logic              clr_number_q, clr_number_d;
    logic              ld_opcode_q, ld_opcode_d;
    logic              clr_opcode_q, clr_opcode_d;
    logic              sel_mux_alu_q, sel_mux_alu_d;
    logic              ld_result_q, ld_result_d;
    logic              clr_result_q, clr_result_d;
    logic              sel_mux_display_q, sel_mux_display_d;
    logic              done_q, done_d;
    logic              err_illegal_q, err_illegal_d;

    logic              cmd_ready_int;
    logic              push, pop, illegal_pop;
    logic [ENT_W-1:0]  head;
    logic [OP_W-1:0]   head_op;
    logic [DATA_W-1:0] head_operand;

    assign cmd_ready_int = (count_q != CNT_W'(DEPTH));
    assign push          = cmd.cmd_valid && cmd_ready_int;
    assign pop           = (state_q == S_IDLE) && (count_q != '0);
    assign head          = mem_q[rd_ptr_q];
    assign head_op       = head[ENT_W-1:DATA_W];
    assign head_operand  = head[DATA_W-1:0];

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        cur_op_d      = cur_op_q;
        cur_operand_d = cur_operand_q;
        illegal_pop   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    cur_op_d      = head_op;
                    cur_operand_d = head_operand;
                    if (head_op == OP_CLEAR) begin
                        state_d = S_CLR;
                    end else if (head_op == OP_LOAD || head_op[OP_W-1]) begin
                        state_d = S_LDNUM;
                    end else begin
                        illegal_pop = 1'b1;
                    end
                end
            end
            S_LDNUM: state_d = (cur_op_q == OP_LOAD) ? S_EXEC : S_LDOP;
            S_LDOP:  state_d = S_EXEC;
            S_EXEC:  state_d = S_SHOW;
            S_SHOW:  state_d = S_IDLE;
            S_CLR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are computed from the next state so they register in step with it.
    always_comb begin
        ld_number_d   = (state_d == S_LDNUM);
        ld_opcode_d   = (state_d == S_LDOP);
        ld_result_d   = (state_d == S_EXEC);
        sel_mux_alu_d = (state_d == S_EXEC) && (cur_op_d != OP_LOAD);
        clr_number_d  = (state_d == S_CLR);
        clr_opcode_d  = (state_d == S_CLR);
        clr_result_d  = (state_d == S_CLR);
        done_d        = (state_d == S_SHOW) || (state_d == S_CLR) || illegal_pop;
        values_d      = (state_d == S_LDNUM) ? cur_operand_d : values_q;
        opcode_out_d  = (state_d == S_LDOP) ? cur_op_d : opcode_out_q;

        sel_mux_display_d = sel_mux_display_q;
        if (state_d == S_LDNUM || state_d == S_CLR) begin
            sel_mux_display_d = 1'b0;
        end else if (state_d == S_SHOW) begin
            sel_mux_display_d = 1'b1;
        end

        err_illegal_d = err_illegal_q;
        if (state_d == S_CLR) begin
            err_illegal_d = 1'b0;
        end else if (illegal_pop) begin
            err_illegal_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
            count_q           <= '0;
            state_q           <= S_IDLE;
            cur_op_q          <= '0;
            cur_operand_q     <= '0;
            values_q          <= '0;
            opcode_out_q      <= '0;
            ld_number_q       <= 1'b0;
            clr_number_q      <= 1'b0;
            ld_opcode_q       <= 1'b0;
            clr_opcode_q      <= 1'b0;
            sel_mux_alu_q     <= 1'b0;
            ld_result_q       <= 1'b0;
            clr_result_q      <= 1'b0;
            sel_mux_display_q <= 1'b0;
            done_q            <= 1'b0;
            err_illegal_q     <= 1'b0;
        end else begin
            wr_ptr_q          <= wr_ptr_d;
            rd_ptr_q          <= rd_ptr_d;
            count_q           <= count_d;
            state_q           <= state_d;
            cur_op_q          <= cur_op_d;
            cur_operand_q     <= cur_operand_d;
            values_q          <= values_d;
            opcode_out_q      <= opcode_out_d;
            ld_number_q       <= ld_number_d;
            clr_number_q      <= clr_number_d;
            ld_opcode_q       <= ld_opcode_d;
            clr_opcode_q      <= clr_opcode_d;
            sel_mux_alu_q     <= sel_mux_alu_d;
            ld_result_q       <= ld_result_d;
            clr_result_q      <= clr_result_d;
            sel_mux_display_q <= sel_mux_display_d;
            done_q            <= done_d;
            err_illegal_q     <= err_illegal_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem_q[wr_ptr_q] <= {cmd.cmd_op, cmd.cmd_operand};
        end
    end

    assign cmd.cmd_ready     = cmd_ready_int;
    assign values            = values_q;
    assign ld_number         = ld_number_q;
    assign clr_number        = clr_number_q;
    assign ld_opcode         = ld_opcode_q;
    assign clr_opcode        = clr_opcode_q;
    assign opcode_out        = opcode_out_q;
    assign sel_mux_alu       = sel_mux_alu_q;
    assign ld_result         = ld_result_q;
    assign clr_result        = clr_result_q;
    assign sel_mux_display   = sel_mux_display_q;
    assign done              = done_q;
    assign err_illegal       = err_illegal_q;
    assign busy              = (state_q != S_IDLE) || (count_q != '0);
    assign state_dbg         = state_q;
endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Directed bench for calc_cmd_sequencer: per-cycle vector table plus hand-written
// sequences for FIFO-full back-pressure and reset mid-command.
module tb_calc_cmd_sequencer;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    calc_cmd_sequencer_if #(.DATA_W(4), .OP_W(3)) cmd_if ();

    logic [3:0] values;
    logic [2:0] opcode_out, state_dbg;
    logic ld_number, clr_number, ld_opcode, clr_opcode, sel_mux_alu;
    logic ld_result, clr_result, sel_mux_display, busy, done, err_illegal;

    calc_cmd_sequencer #(.DEPTH(DEPTH), .DATA_W(4), .OP_W(3)) dut (
        .clk(clk), .reset(reset), .cmd(cmd_if),
        .values(values), .ld_number(ld_number), .clr_number(clr_number),
        .ld_opcode(ld_opcode), .clr_opcode(clr_opcode), .opcode_out(opcode_out),
        .sel_mux_alu(sel_mux_alu), .ld_result(ld_result), .clr_result(clr_result),
        .sel_mux_display(sel_mux_display), .busy(busy), .done(done),
        .err_illegal(err_illegal), .state_dbg(state_dbg)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural datapath and strobe monitor, sampled mid-cycle.
    logic [3:0] dp_in = '0, dp_acc = '0;
    logic [2:0] dp_opc = '0;
    int         done_cnt = 0;
    logic [3:0] seen_opnd[$];
    logic [2:0] seen_op[$];

    function automatic logic [3:0] alu(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            3'b100:  return a + b;
            3'b101:  return a - b;
            3'b110:  return a & b;
            default: return a | b;
        endcase
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            if (done) done_cnt++;
            if (ld_number) seen_opnd.push_back(values);
            if (ld_opcode) seen_op.push_back(opcode_out);
            if (ld_result) dp_acc = sel_mux_alu ? alu(dp_opc, dp_acc, dp_in) : dp_in;
            else if (clr_result) dp_acc = '0;
            if (ld_number) dp_in = values;
            else if (clr_number) dp_in = '0;
            if (ld_opcode) dp_opc = opcode_out;
            else if (clr_opcode) dp_opc = '0;
        end
    end

    function automatic logic [3:0] display();
        return sel_mux_display ? dp_acc : dp_in;
    endfunction

    // ld_n clr_n ld_o clr_o | alu ld_r clr_r disp | done busy err ready
    function automatic logic [21:0] out_vec();
        return {state_dbg, values, opcode_out,
                ld_number, clr_number, ld_opcode, clr_opcode,
                sel_mux_alu, ld_result, clr_result, sel_mux_display,
                done, busy, err_illegal, cmd_if.cmd_ready};
    endfunction

    function automatic logic strobe_any();
        return ld_number | clr_number | ld_opcode | clr_opcode | ld_result | clr_result | done;
    endfunction

    typedef struct {
        logic        v;
        logic [2:0]  op;
        logic [3:0]  opnd;
        logic [2:0]  st;
        logic [3:0]  val;
        logic [2:0]  opc;
        logic [11:0] strb;
    } vec_t;

    vec_t tbl[16];

    task automatic push_cmd(input logic [2:0] op, input logic [3:0] opnd, output int waited);
        logic acc;
        acc = 1'b0;
        waited = 0;
        cmd_if.cmd_valid   = 1'b1;
        cmd_if.cmd_op      = op;
        cmd_if.cmd_operand = opnd;
        for (int k = 0; k < 100; k++) begin
            acc = cmd_if.cmd_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            waited++;
        end
        cmd_if.cmd_valid = 1'b0;
        chk("push_accept", {31'd0, acc}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, d0, qs, qo, n;
        logic any;
        logic [3:0] exp_opnd[6];
        logic [2:0] exp_op[5];

        tbl[0]  = '{1'b1, 3'b001, 4'd4, 3'd0, 4'd0, 3'd0, 12'b0000_0000_0101};
        tbl[1]  = '{1'b1, 3'b100, 4'd5, 3'd1, 4'd4, 3'd0, 12'b1000_0000_0101};
        tbl[2]  = '{1'b0, 3'b000, 4'd0, 3'd3, 4'd4, 3'd0, 12'b0000_0100_0101};
        tbl[3]  = '{1'b0, 3'b000, 4'd0, 3'd4, 4'd4, 3'd0, 12'b0000_0001_1101};
        tbl[4]  = '{1'b0, 3'b000, 4'd0, 3'd0, 4'd4, 3'd0, 12'b0000_0001_0101};
        tbl[5]  = '{1'b0, 3'b000, 4'd0, 3'd1, 4'd5, 3'd0, 12'b1000_0000_0101};
        tbl[6]  = '{1'b0, 3'b000, 4'd0, 3'd2, 4'd5, 3'd4, 12'b0010_0000_0101};
        tbl[7]  = '{1'b0, 3'b000, 4'd0, 3'd3, 4'd5, 3'd4, 12'b0000_1100_0101};
        tbl[8]  = '{1'b0, 3'b000, 4'd0, 3'd4, 4'd5, 3'd4, 12'b0000_0001_1101};
        tbl[9]  = '{1'b0, 3'b000, 4'd0, 3'd0, 4'd5, 3'd4, 12'b0000_0001_0001};
        tbl[10] = '{1'b1, 3'b010, 4'd3, 3'd0, 4'd5, 3'd4, 12'b0000_0001_0101};
        tbl[11] = '{1'b0, 3'b000, 4'd0, 3'd0, 4'd5, 3'd4, 12'b0000_0001_1011};
        tbl[12] = '{1'b0, 3'b000, 4'd0, 3'd0, 4'd5, 3'd4, 12'b0000_0001_0011};
        tbl[13] = '{1'b1, 3'b000, 4'd7, 3'd0, 4'd5, 3'd4, 12'b0000_0001_0111};
        tbl[14] = '{1'b0, 3'b000, 4'd0, 3'd5, 4'd5, 3'd4, 12'b0101_0010_1101};
        tbl[15] = '{1'b0, 3'b000, 4'd0, 3'd0, 4'd5, 3'd4, 12'b0000_0000_0001};

        exp_opnd = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        exp_op   = '{3'b100, 3'b101, 3'b110, 3'b111, 3'b100};

        // Reset held with a command offered: nothing may be accepted.
        reset = 1'b0;
        cmd_if.cmd_valid   = 1'b1;
        cmd_if.cmd_op      = 3'b001;
        cmd_if.cmd_operand = 4'd9;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("reset_outputs", {10'd0, out_vec()}, {10'd0, 3'd0, 4'd0, 3'd0, 12'b0000_0000_0001});
        end
        chk("reset_count", 32'(dut.count_q), 32'd0);
        cmd_if.cmd_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("after_release_busy", {31'd0, busy}, 32'd0);

        // Cycle table: LOAD 4, ADD 5, illegal op, then CLEAR.
        d0 = done_cnt;
        for (int i = 0; i < 16; i++) begin
            cmd_if.cmd_valid   = tbl[i].v;
            cmd_if.cmd_op      = tbl[i].op;
            cmd_if.cmd_operand = tbl[i].opnd;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), {10'd0, out_vec()},
                {10'd0, tbl[i].st, tbl[i].val, tbl[i].opc, tbl[i].strb});
            if (i == 9) begin
                chk("load_add_done_pulses", done_cnt - d0, 32'd2);
                chk("display_sum", {28'd0, display()}, 32'd9);
            end
            if (i == 15) begin
                chk("all_done_pulses", done_cnt - d0, 32'd4);
                chk("display_cleared", {28'd0, display()}, 32'd0);
            end
        end
        cmd_if.cmd_valid = 1'b0;

        // Back-pressure: queue DEPTH+1 commands behind a running ALU op.
        qs = seen_opnd.size();
        qo = seen_op.size();
        d0 = done_cnt;
        push_cmd(3'b100, 4'd1, w);
        @(posedge clk);
        #1;
        push_cmd(3'b101, 4'd2, w);
        push_cmd(3'b110, 4'd3, w);
        push_cmd(3'b111, 4'd4, w);
        push_cmd(3'b001, 4'd5, w);
        chk("full_ready_low", {31'd0, cmd_if.cmd_ready}, 32'd0);
        chk("full_count", 32'(dut.count_q), DEPTH);
        push_cmd(3'b100, 4'd6, w);
        chk("extra_stalled", {31'd0, (w > 0)}, 32'd1);
        chk("refill_count", 32'(dut.count_q), DEPTH);
        chk("refill_ready_low", {31'd0, cmd_if.cmd_ready}, 32'd0);
        for (int k = 0; k < 300 && busy; k++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        chk("drain_idle", {31'd0, busy}, 32'd0);
        chk("order_opnd_count", seen_opnd.size() - qs, 32'd6);
        chk("order_op_count", seen_op.size() - qo, 32'd5);
        chk("order_done_count", done_cnt - d0, 32'd6);
        n = seen_opnd.size() - qs;
        for (int k = 0; k < 6 && k < n; k++)
            chk($sformatf("order_opnd%0d", k), {28'd0, seen_opnd[qs+k]}, {28'd0, exp_opnd[k]});
        n = seen_op.size() - qo;
        for (int k = 0; k < 5 && k < n; k++)
            chk($sformatf("order_op%0d", k), {29'd0, seen_op[qo+k]}, {29'd0, exp_op[k]});

        // Reset during EXEC with two commands still queued.
        push_cmd(3'b100, 4'd3, w);
        push_cmd(3'b101, 4'd4, w);
        push_cmd(3'b110, 4'd5, w);
        for (int k = 0; k < 20 && state_dbg != 3'd3; k++) begin
            @(posedge clk);
            #1;
        end
        chk("reached_exec", {29'd0, state_dbg}, 32'd3);
        chk("queued_two", 32'(dut.count_q), 32'd2);
        reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk("rst_state", {29'd0, state_dbg}, 32'd0);
        chk("rst_count", 32'(dut.count_q), 32'd0);
        chk("rst_flags", {28'd0, busy, cmd_if.cmd_ready, err_illegal, sel_mux_display}, 32'b0100);
        any = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            any = any | strobe_any() | busy;
        end
        chk("post_reset_quiet", {31'd0, any}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
